// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the multiply/divide sequencer and the control FSM
// that drives it.
package cpu_defs;

    typedef enum logic [1:0] {
        ST_MD_IDLE = 2'd0,
        ST_MD_CALC = 2'd1,
        ST_MD_FIX  = 2'd2,
        ST_MD_DONE = 2'd3
    } md_state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;

    // The control FSM maps the R-type funct field onto the op_div select.
    function automatic logic md_op_from_funct(input logic [5:0] funct);
        return (funct == FUNCT_DIV) ? OP_DIV : OP_MULT;
    endfunction

endpackage

// File: rtl/md_step.sv
// One combinational iteration of the multiply/divide loop on unsigned magnitudes.
// MULT: shift-add on {partial, multiplier}. DIV: restoring step on {remainder, quotient}.
module md_step
    import cpu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 mode,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic                 q_bit
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        // The shifted remainder is below 2*operand, so a passing trial fits in WIDTH bits.
        rem_sub  = rem_sh[WIDTH-1:0] - operand;
        q_bit    = 1'b0;
        acc_next = {mul_sum, acc[WIDTH-1:1]};
        if (mode == OP_DIV) begin
            q_bit    = (rem_sh >= {1'b0, operand});
            acc_next = {(q_bit ? rem_sub : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};
        end
    end

endmodule

// File: rtl/mult_div_seq.sv
// Multicycle signed MULT/DIV sequencer owning the HI/LO pair; one iteration per clock,
// sign correction in a final fix-up cycle, result presented with a one-cycle done pulse.
module mult_div_seq
    import cpu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    md_state_t            state, next_state;
    logic [CNT_W-1:0]     counter;
    logic                 op_div_r, sign_a, sign_b;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc, acc_next;
    logic                 q_bit_unused;
    logic [WIDTH-1:0]     mag_a_in, mag_b_in;
    logic [2*WIDTH-1:0]   prod_neg;
    logic [WIDTH-1:0]     quot, rem, quot_fix, rem_fix;

    md_step #(.WIDTH(WIDTH)) u_step (
        .mode     (op_div_r),
        .acc      (acc),
        .operand  (mag_b),
        .acc_next (acc_next),
        .q_bit    (q_bit_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_MD_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_MD_IDLE: if (start) next_state = ST_MD_CALC;
            ST_MD_CALC: if (counter == LAST_ITER) next_state = ST_MD_FIX;
            ST_MD_FIX:  next_state = ST_MD_DONE;
            ST_MD_DONE: next_state = ST_MD_IDLE;
            default:    next_state = ST_MD_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_MD_IDLE);
        done = (state == ST_MD_DONE);
    end

    always_comb begin
        mag_a_in = a[WIDTH-1] ? (~a + 1'b1) : a;
        mag_b_in = b[WIDTH-1] ? (~b + 1'b1) : b;
        prod_neg = ~acc + {{(2*WIDTH-1){1'b0}}, 1'b1};
        quot     = acc[WIDTH-1:0];
        rem      = acc[2*WIDTH-1:WIDTH];
        quot_fix = (sign_a ^ sign_b) ? (~quot + 1'b1) : quot;
        rem_fix  = sign_a ? (~rem + 1'b1) : rem;
    end

    // Datapath: operand capture, iteration, and the only place HI/LO are written.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter  <= '0;
            op_div_r <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            mag_b    <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                ST_MD_IDLE: if (start) begin
                    op_div_r <= op_div;
                    sign_a   <= a[WIDTH-1];
                    sign_b   <= b[WIDTH-1];
                    mag_b    <= mag_b_in;
                    acc      <= {{WIDTH{1'b0}}, mag_a_in};
                    div_zero <= 1'b0;
                    counter  <= '0;
                end
                ST_MD_CALC: begin
                    acc     <= acc_next;
                    counter <= counter + 1'b1;
                end
                ST_MD_FIX: begin
                    if (op_div_r == OP_DIV) begin
                        if (mag_b == '0) begin
                            div_zero <= 1'b1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                    end else begin
                        {hi, lo} <= (sign_a ^ sign_b) ? prod_neg : acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: table-driven MULT/DIV vectors plus hand sequences
// for divide-by-zero, ignored start, back-to-back issue and mid-operation reset.
module tb_mult_div_seq;
    import cpu_defs::*;

    localparam int W   = 32;
    localparam int LAT = 33;

    typedef struct {
        string      name;
        logic       op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic       dz;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset, start, op_div;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;

    vec_t vecs [10];

    mult_div_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_div   (op_div),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one op from an IDLE cycle and follows it to done; optionally pulses a
    // second start with different operands while the first op is running.
    task automatic apply_stimulus(input logic op, input logic [W-1:0] va, input logic [W-1:0] vb,
                                  input int inject_at, output int lat,
                                  output logic busy_ok, output logic stable_ok);
        logic [W-1:0] h0, l0;
        h0 = hi;
        l0 = lo;
        start = 1'b1; op_div = op; a = va; b = vb;
        @(posedge clk); #1;
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0000_0064; op_div = ~op;
        lat = -1; busy_ok = 1'b1; stable_ok = 1'b1;
        if (!busy) busy_ok = 1'b0;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            start = (n == inject_at);
            @(posedge clk); #1;
            start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (done) lat = n;
            else if (hi !== h0 || lo !== l0) stable_ok = 1'b0;
        end
    endtask

    task automatic run_check(input string name, input logic op, input logic [W-1:0] va,
                             input logic [W-1:0] vb, input int inject_at,
                             input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                             input logic exp_dz);
        int   lat;
        logic busy_ok, stable_ok;
        apply_stimulus(op, va, vb, inject_at, lat, busy_ok, stable_ok);
        check_output({name, " latency"}, W'(lat), W'(LAT));
        check_output({name, " busy_held"}, {31'b0, busy_ok}, 32'd1);
        check_output({name, " hilo_stable"}, {31'b0, stable_ok}, 32'd1);
        check_output({name, " hi"}, hi, exp_hi);
        check_output({name, " lo"}, lo, exp_lo);
        check_output({name, " div_zero"}, {31'b0, div_zero}, {31'b0, exp_dz});
        @(posedge clk); #1;
        check_output({name, " idle_after"}, {30'b0, busy, done}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{"mul_7_m3",    OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{"mul_max_max", OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[2] = '{"div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{"div_min_m1",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[4] = '{"mul_min_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[5] = '{"div_100_7",   OP_DIV,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
        vecs[6] = '{"div_7_m2",    OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[7] = '{"div_m8_m3",   OP_DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, 1'b0};
        vecs[8] = '{"mul_m1_m1",   OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[9] = '{"div_set_hilo",OP_DIV,  32'h0000_0451, 32'h0000_0020, 32'h0000_0011, 32'h0000_0022, 1'b0};

        reset = 1'b1; start = 1'b0; op_div = OP_MULT; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset busy_done_dz", {29'b0, busy, done, div_zero}, 32'd0);
        check_output("reset hi", hi, 32'd0);
        check_output("reset lo", lo, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            run_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 0,
                      vecs[i].hi, vecs[i].lo, vecs[i].dz);

        $display("[TB] divide by zero keeps HI/LO");
        run_check("div_by_zero", OP_DIV, 32'h0000_0005, 32'h0000_0000, 0,
                  32'h0000_0011, 32'h0000_0022, 1'b1);
        check_output("div_zero held in idle", {31'b0, div_zero}, 32'd1);
        run_check("mul_after_dz", OP_MULT, 32'h0000_0003, 32'h0000_0004, 0,
                  32'h0000_0000, 32'h0000_000C, 1'b0);

        $display("[TB] start while busy is ignored");
        run_check("mul_inject", OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 5,
                  32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_check("back_to_back", OP_MULT, 32'h0000_0010, 32'h0000_0010, 0,
                  32'h0000_0000, 32'h0000_0100, 1'b0);

        $display("[TB] reset in mid-operation");
        start = 1'b1; op_div = OP_MULT; a = 32'h0000_0007; b = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_output("midreset busy_done", {30'b0, busy, done}, 32'd0);
        check_output("midreset hi", hi, 32'd0);
        check_output("midreset lo", lo, 32'd0);
        run_check("after_reset", OP_DIV, 32'h0000_0064, 32'hFFFF_FFF9, 0,
                  32'h0000_0002, 32'hFFFF_FFF2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
